decode_stage: RTL and testbench

- Pipelined instruction-decode stage between fetch and execute in the RV32 core.
- Accepts fetched instruction/PC words over a valid/ready handshake and instantiates the immediate generator.
- Registers the sign-extended immediate, R-type flag and an illegal-opcode flag alongside the instruction.
- Holds results in a 2-entry skid buffer so backpressure never drops data; supports a pipeline flush.

---
 rtl/rv32_pkg.sv | 28 ++
 rtl/decode_stage_imm_gen.sv | 33 +++
 rtl/decode_stage.sv | 120 ++++++++++++
 tb/tb_decode_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 opcode constants and the decoded-entry bundle
// used between the decode stage and its helpers.
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int OP_LEN = 7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic            is_R;
        logic            illegal;
    } dec_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// decode_stage_imm_gen: sign-extended immediate for every RV32 format;
// zero for R-type, FENCE/SYSTEM and unrecognised opcodes.
module decode_stage_imm_gen
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm
);

    // Pick the immediate layout from the opcode field.
    always_comb begin
        imm = '0;
        unique case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25],
                       instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31],
                       instr[19:12], instr[20],
                       instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32 decode with a 2-entry skid buffer
// (output register O + skid register S) and pipeline flush.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int XLEN   = rv32_pkg::XLEN,
    parameter int OP_LEN = rv32_pkg::OP_LEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic            out_is_type_R,
    output logic            out_illegal,
    output logic [31:0]     decode_count
);

    logic [XLEN-1:0]   imm;
    logic [OP_LEN-1:0] opcode;
    logic              is_R;
    logic              illegal;
    dec_t              dec_in;
    dec_t              o_q;
    dec_t              s_q;
    logic              o_valid;
    logic              s_valid;
    logic [31:0]       count_q;
    logic              accept;
    logic              transfer;

    decode_stage_imm_gen u_imm (
        .instr (in_instr),
        .imm   (imm)
    );

    assign opcode = in_instr[OP_LEN-1:0];

    // Opcode legality and R-type flag; low bits 2'b11 are
    // implied by every supported opcode value.
    always_comb begin
        is_R    = 1'b0;
        illegal = 1'b0;
        unique case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_STORE,
            OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL,
            OP_FENCE, OP_SYSTEM:
                illegal = 1'b0;
            OP_OP:
                is_R = 1'b1;
            default:
                illegal = 1'b1;
        endcase
    end

    assign dec_in = '{instr:   in_instr,
                      pc:      in_pc,
                      imm:     imm,
                      is_R:    is_R,
                      illegal: illegal};

    assign in_ready = ~s_valid;
    assign accept   = in_valid & ~s_valid;
    assign transfer = o_valid & out_ready;

    // Skid buffer control: EMPTY -> ONE -> FULL and back, FIFO order.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            s_valid <= 1'b0;
            o_q     <= '0;
            s_q     <= '0;
        end else if (flush) begin
            o_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (!o_valid) begin
            if (accept) begin
                o_q     <= dec_in;
                o_valid <= 1'b1;
            end
        end else if (!s_valid) begin
            if (accept && transfer) begin
                o_q <= dec_in;
            end else if (accept) begin
                s_q     <= dec_in;
                s_valid <= 1'b1;
            end else if (transfer) begin
                o_valid <= 1'b0;
            end
        end else if (transfer) begin
            o_q     <= s_q;
            s_valid <= 1'b0;
        end
    end

    // Handed-downstream counter; a transfer during flush still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (transfer) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign out_valid     = o_valid;
    assign out_instr     = o_q.instr;
    assign out_pc        = o_q.pc;
    assign out_imm       = o_q.imm;
    assign out_is_type_R = o_q.is_R;
    assign out_illegal   = o_q.illegal;
    assign decode_count  = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage
// against a FIFO-of-capacity-2 reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic        out_is_type_R;
    logic        out_illegal;
    logic [31:0] decode_count;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        r;
        logic        ill;
    } ent_t;

    ent_t        q[$];
    logic [31:0] cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_imm       (out_imm),
        .out_is_type_R (out_is_type_R),
        .out_illegal   (out_illegal),
        .decode_count  (decode_count)
    );

    always #5 clk = ~clk;

    // Reference decode from the instruction-format rules.
    function automatic ent_t ref_dec(input logic [31:0] ins,
                                     input logic [31:0] pc);
        ent_t e;
        logic [31:0] s20, s19, s11;
        s20 = 32'($signed(ins) >>> 20);
        s19 = 32'($signed(ins) >>> 19);
        s11 = 32'($signed(ins) >>> 11);
        e.instr = ins;
        e.pc    = pc;
        e.imm   = 32'h0;
        e.r     = 1'b0;
        e.ill   = 1'b0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: e.imm = s20;
            7'h23: e.imm = (s20 & ~32'h1F) | 32'(ins[11:7]);
            7'h63: e.imm = (s19 & 32'hFFFFF000)
                         | (32'(ins[7]) << 11)
                         | (32'(ins[30:25]) << 5)
                         | (32'(ins[11:8]) << 1);
            7'h37, 7'h17: e.imm = ins & 32'hFFFFF000;
            7'h6F: e.imm = (s11 & 32'hFFF00000)
                         | (ins & 32'h000FF000)
                         | (32'(ins[20]) << 11)
                         | (32'(ins[30:21]) << 1);
            7'h33: e.r = 1'b1;
            7'h0F, 7'h73: e.imm = 32'h0;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // One cycle: drive at negedge, advance the model at the edge.
    task automatic step(input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic ordy,
                        input logic fl);
        logic acc, xfer;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        acc  = v && (q.size() < 2);
        xfer = ordy && (q.size() > 0);
        @(posedge clk);
        if (xfer) begin
            void'(q.pop_front());
            cnt = cnt + 32'd1;
        end
        if (fl) q.delete();
        else if (acc) q.push_back(ref_dec(ins, pc));
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
        in_instr = 32'h00500093; in_pc = 32'h40;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        q.delete(); cnt = 32'h0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_hs got %b want 01",
                     {out_valid, in_ready});
        end
        n_cmp++;
        if ({out_instr, out_pc, out_imm, out_is_type_R,
             out_illegal, decode_count} !== '0) begin
            n_err++;
            $display("FAIL reset_data instr=%h pc=%h imm=%h cnt=%h want 0",
                     out_instr, out_pc, out_imm, decode_count);
        end
    endtask

    task automatic test_addi;
        step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
        n_cmp++;
        if ({out_valid, out_imm, out_pc, out_illegal} !==
            {1'b1, 32'h5, 32'h100, 1'b0}) begin
            n_err++;
            $display("FAIL addi got v=%b imm=%h pc=%h ill=%b want 1/5/100/0",
                     out_valid, out_imm, out_pc, out_illegal);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if ({out_valid, decode_count} !== {1'b0, 32'd1}) begin
            n_err++;
            $display("FAIL addi_count got v=%b cnt=%0d want 0/1",
                     out_valid, decode_count);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ins [3];
        logic [31:0] imm [3];
        ins[0] = 32'h00112223; imm[0] = 32'h00000004;
        ins[1] = 32'hFE000EE3; imm[1] = 32'hFFFFFFFC;
        ins[2] = 32'h123450B7; imm[2] = 32'h12345000;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ins[i], 32'h200 + 32'(4 * i), 1'b1, 1'b0);
            n_cmp++;
            if ({out_valid, in_ready, out_instr, out_imm} !==
                {2'b11, ins[i], imm[i]}) begin
                n_err++;
                $display("FAIL b2b_%0d got v=%b rdy=%b instr=%h imm=%h want %h/%h",
                         i, out_valid, in_ready, out_instr, out_imm,
                         ins[i], imm[i]);
            end
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (decode_count !== cnt) begin
            n_err++;
            $display("FAIL b2b_count got %0d want %0d",
                     decode_count, cnt);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] ins [3];
        ins[0] = 32'h00A00113;
        ins[1] = 32'h002081B3;
        ins[2] = 32'h0000006F;
        step(1'b1, ins[0], 32'h300, 1'b0, 1'b0);
        step(1'b1, ins[1], 32'h304, 1'b0, 1'b0);
        n_cmp++;
        if ({out_valid, in_ready, out_instr} !==
            {2'b10, ins[0]}) begin
            n_err++;
            $display("FAIL bp_full got v=%b rdy=%b instr=%h want 1/0/%h",
                     out_valid, in_ready, out_instr, ins[0]);
        end
        step(1'b1, ins[2], 32'h308, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({out_valid, out_instr} !== {1'b1, ins[i]}) begin
                n_err++;
                $display("FAIL bp_drain_%0d got v=%b instr=%h want %h",
                         i, out_valid, out_instr, ins[i]);
            end
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        n_cmp++;
        if ({out_valid, in_ready, q.size() == 0} !== 3'b011) begin
            n_err++;
            $display("FAIL bp_empty got v=%b rdy=%b want 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_illegal;
        logic [31:0] ins [3];
        logic [1:0]  fl [3];
        ins[0] = 32'h00000000; fl[0] = 2'b01;
        ins[1] = 32'h0000007F; fl[1] = 2'b01;
        ins[2] = 32'h002081B3; fl[2] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ins[i], 32'h400, 1'b1, 1'b0);
            n_cmp++;
            if ({out_is_type_R, out_illegal, out_imm} !==
                {fl[i], 32'h0}) begin
                n_err++;
                $display("FAIL illegal_%0d got R=%b ill=%b imm=%h want %b/0",
                         i, out_is_type_R, out_illegal, out_imm, fl[i]);
            end
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush;
        logic [31:0] c0;
        step(1'b1, 32'h00100093, 32'h500, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 32'h504, 1'b0, 1'b0);
        step(1'b1, 32'h00300093, 32'h508, 1'b0, 1'b1);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL flush_full got v=%b rdy=%b want 0/1",
                     out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_stale_%0d got v=%b want 0",
                         i, out_valid);
            end
        end
        step(1'b1, 32'h00400093, 32'h50C, 1'b0, 1'b0);
        c0 = decode_count;
        step(1'b1, 32'h00500093, 32'h510, 1'b1, 1'b1);
        n_cmp++;
        if ({out_valid, decode_count} !==
            {1'b0, c0 + 32'd1}) begin
            n_err++;
            $display("FAIL flush_xfer got v=%b cnt=%0d want 0/%0d",
                     out_valid, decode_count, c0 + 32'd1);
        end
    endtask

    task automatic test_random;
        logic [6:0]  ops [12];
        logic [31:0] ins;
        ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73, 7'h00};
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 7) != 0)
                ins[6:0] = ops[$urandom_range(0, 11)];
            step(1'($urandom_range(0, 1)), ins, $urandom,
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0));
            n_cmp++;
            if ({out_valid, in_ready, decode_count} !==
                {q.size() > 0, q.size() < 2, cnt}) begin
                n_err++;
                $display("FAIL rand_hs_%0d got v=%b rdy=%b cnt=%0d want %0d entries cnt=%0d",
                         i, out_valid, in_ready, decode_count,
                         q.size(), cnt);
            end
            if (q.size() > 0) begin
                n_cmp++;
                if ({out_instr, out_pc, out_imm, out_is_type_R,
                     out_illegal} !==
                    {q[0].instr, q[0].pc, q[0].imm, q[0].r,
                     q[0].ill}) begin
                    n_err++;
                    $display("FAIL rand_data_%0d got %h/%h/%h/%b%b want %h/%h/%h/%b%b",
                             i, out_instr, out_pc, out_imm,
                             out_is_type_R, out_illegal,
                             q[0].instr, q[0].pc, q[0].imm,
                             q[0].r, q[0].ill);
                end
            end
        end
        while (q.size() > 0) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_rst_mid;
        step(1'b1, 32'h00700093, 32'h600, 1'b0, 1'b0);
        step(1'b1, 32'h00800093, 32'h604, 1'b0, 1'b0);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        q.delete(); cnt = 32'h0;
        n_cmp++;
        if ({out_valid, in_ready, out_instr, out_pc, out_imm,
             out_is_type_R, out_illegal, decode_count} !==
            {2'b01, 130'h0}) begin
            n_err++;
            $display("FAIL rst_mid got v=%b rdy=%b instr=%h cnt=%0d want 0/1/0/0",
                     out_valid, in_ready, out_instr, decode_count);
        end
    endtask

    task automatic test_wrap;
        step(1'b1, 32'h00900093, 32'h700, 1'b0, 1'b0);
        force dut.count_q = 32'hFFFFFFFF;
        #1;
        release dut.count_q;
        cnt = 32'hFFFFFFFF;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (decode_count !== 32'h0) begin
            n_err++;
            $display("FAIL wrap got %h want 00000000",
                     decode_count);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0; out_ready = 1'b0;
        cnt = 32'h0;
        @(negedge clk);
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_flush();
        test_random();
        test_rst_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
